// File: rtl/mac_tx_fcs_inserter.sv
// rtl/mac_tx_fcs_inserter.sv - TX framing stage: forwards payload, pads short frames, appends FCS
// Bytes go out combinationally in DATA; the CRC engine result is latched once per frame and sent LSB first.
module mac_tx_fcs_inserter #(
  parameter int         MIN_BYTES = 60,
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter int         CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        crc_sof,
  output logic        crc_valid,
  output logic [7:0]  crc_data,
  output logic        crc_last,
  input  logic [31:0] crc_in,
  input  logic        crc_done
);

  typedef enum logic [1:0] {DATA, PAD, WAIT_CRC, FCS} state_t;

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BYTES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       fcs_idx_q, fcs_idx_d;
  logic [31:0]      fcs_q, fcs_d;
  logic             run_q, run_d;
  logic             fire;
  logic             reach_min;

  assign run_d = 1'b1;

  // cnt saturates at MIN_CNT, so cnt+1 never wraps in the comparison below
  assign cnt_inc   = (cnt_q < MIN_CNT) ? cnt_q + 1'b1 : cnt_q;
  assign reach_min = (cnt_q + 1'b1) >= MIN_CNT;
  assign crc_data  = m_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcs_idx_d = fcs_idx_q;
    fcs_d     = fcs_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = s_data;
    m_last    = 1'b0;
    crc_valid = 1'b0;
    crc_sof   = 1'b0;
    crc_last  = 1'b0;
    fire      = 1'b0;
    case (state_q)
      DATA: begin
        m_valid = run_q & s_valid;
        s_ready = run_q & m_ready;
        fire    = m_valid & m_ready;
        if (fire) begin
          crc_valid = 1'b1;
          crc_sof   = (cnt_q == '0);
          cnt_d     = cnt_inc;
          if (s_last) begin
            if (reach_min) begin
              crc_last = 1'b1;
              state_d  = WAIT_CRC;
            end else begin
              state_d  = PAD;
            end
          end
        end
      end
      PAD: begin
        m_valid = run_q;
        m_data  = PAD_BYTE;
        fire    = m_valid & m_ready;
        if (fire) begin
          crc_valid = 1'b1;
          cnt_d     = cnt_inc;
          if (reach_min) begin
            crc_last = 1'b1;
            state_d  = WAIT_CRC;
          end
        end
      end
      WAIT_CRC: begin
        if (crc_done) begin
          fcs_d     = crc_in;
          fcs_idx_d = 2'd0;
          state_d   = FCS;
        end
      end
      FCS: begin
        m_valid = run_q;
        m_data  = fcs_q[{fcs_idx_q, 3'b000} +: 8];
        m_last  = (fcs_idx_q == 2'd3);
        fire    = m_valid & m_ready;
        if (fire) begin
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (m_last) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DATA;
      cnt_q     <= '0;
      fcs_idx_q <= 2'd0;
      fcs_q     <= 32'h0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcs_idx_q <= fcs_idx_d;
      fcs_q     <= fcs_d;
      run_q     <= run_d;
    end
  end

endmodule
